uart_hello_rx: RTL and testbench
================================

# uart_hello_rx

Receive-side counterpart of the "Hello World!\n" UART sender. It deserialises 8N1 UART frames from the `rx` pin, presents each byte with a one-cycle valid strobe, and checks every newline-terminated line against the constant string "Hello World!\n". It reports per-line pass/fail pulses and a saturating pass counter. It sits at the board pin and can loop back the sender's `tx` for self-test.

## Interface
- `FREQ_CLKIN`, default 100_000_000: input clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in baud. DIV = FREQ_CLKIN / BAUD_RATE, truncated; DIV ≥ 8 required.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART line, idle high, asynchronous to `clk`.
- `rx_debug`  out  1  equals `rx` (combinational, for logic analyser).
- `rx_data`  out  8  last received byte; holds until the next valid byte.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` is new.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low.
- `line_ok`  out  1  one-cycle strobe, line matched exactly.
- `line_bad`  out  1  one-cycle strobe, line terminated but did not match.
- `match_count`  out  16  number of `line_ok` events, saturating at 0xFFFF.

## Operation
- `rx` passes through a 2-flop synchroniser, reset value 1. All logic below uses the synchronised value `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. The FSM uses a baud counter of width clog2(DIV) and a 3-bit bit index.
  - **IDLE:** a falling edge on `rxs` (previous 1, current 0) goes to START with the counter cleared.
  - **START:** when the counter reaches DIV/2−1, sample. If the sample is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE.
  - **DATA:** every DIV cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - **STOP:** after DIV cycles, sample.
    - Sample 1: latch `rx_data` and pulse `rx_valid`, then go to IDLE.
    - Sample 0: pulse `frame_err` with no `rx_valid` and no `rx_data` update, then go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rxs`=1, then go to IDLE. A held-low break therefore yields exactly one `frame_err`.
- Line checker state: index `idx` (0..12) and a sticky `mism` flag. It acts on `rx_valid` and `frame_err`.
  - `frame_err`: set `mism`.
  - Byte == 0x0A:
    - If `mism`=0 and `idx`=12: pulse `line_ok` and increment `match_count` (saturating).
    - Otherwise: pulse `line_bad`.
    - In both cases clear `idx` and `mism`.
  - Other byte, `idx`<12, byte equals "Hello World!\n"[idx]: `idx`++.
  - Any other byte: set `mism`. `idx` holds. This covers lines longer than 12 characters and wrong characters.
- A lone "\n" gives `line_bad`.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`/`frame_err`/`line_ok`/`line_bad`=0, `match_count`=0. Internally: FSM=IDLE, `idx`=0, `mism`=0, synchroniser=1.
- Let T be the cycle in which IDLE sees the falling edge on `rxs`. T is 2–3 cycles after the pin edge.
  - Start-bit sample at T+DIV/2.
  - Data bit i sample at T+DIV/2+(i+1)·DIV.
  - Stop-bit sample at T+DIV/2+9·DIV.
  - `rx_valid` or `frame_err` is high in the cycle after the stop sample.
- `line_ok`/`line_bad` are asserted one cycle after the `rx_valid` of the "\n" byte. `match_count` updates in that same cycle.
- Back-to-back frames: IDLE is re-entered in the cycle of the strobe. This tolerates a stop bit as short as DIV/2.
- Reset mid-frame aborts the frame and the line with no strobes. Outputs return to reset values asynchronously.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each start, data and stop sample is the 2-of-3 majority of `rxs` at counter values DIV/2−2, DIV/2−1 and DIV/2. Data, stop and START-glitch decisions use the vote.
- Undefined: single sample at DIV/2−1. Timing of strobes is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - receiver state encoding;
  - `HELLO_STR` ("Hello World!\n");
  - `HELLO_LEN`=13;
  - `ASCII_LF`=8'h0A.
- The sender side uses the same string constant from `uart_pkg`.
- One sub-module `uart_rx` holds the synchroniser, FSM and baud counter, and outputs `rx_data`/`rx_valid`/`frame_err`.
- The top level holds the line checker and counter.

## Test plan
Bench parameters: FREQ_CLKIN=1_600_000, BAUD_RATE=100_000 (DIV=16).
- **Single byte:** send 0x55 → `rx_valid` once, `rx_data`=0x55, at T+8+9·16+1. `frame_err` stays 0.
- **Exact line:** send "Hello World!\n" back-to-back → 13 `rx_valid`, then `line_ok` once, `match_count`=1, `line_bad` never.
- **Mismatched lines:** send "Hello world!\n", then "Hello World!!\n", then "\n" → three `line_bad` pulses, `match_count`=0.
- **Framing error:** stop bit forced low for 40 cycles, then "Hello World!\n" → `frame_err` once, no `rx_valid` for that frame, following line gives `line_ok`.
- **Glitch and reset:** a 3-cycle low glitch on idle line gives no strobes. Asserting `rst` during data bit 4 clears everything, and the next full frame of 0xA3 is received correctly.
- **Saturation:** preload via 65 535 matching lines (or a forced counter) → an additional `line_ok` leaves `match_count`=0xFFFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding and the "Hello World!\n" reference line
// used by both the sender and the receive-side line checker.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned HELLO_LEN = 13;
  localparam logic [8*HELLO_LEN-1:0] HELLO_STR = "Hello World!\n";
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Character idx of HELLO_STR; the string literal packs its first character in the top byte.
  function automatic logic [7:0] hello_char(input logic [3:0] idx);
    return HELLO_STR[8*(int'(HELLO_LEN) - 1 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, baud counter and receive FSM.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote per sample).
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         UART line, idle high, asynchronous to clk
//   rx_data    last good byte, held until the next one
//   rx_valid   one-cycle strobe, rx_data is new
//   frame_err  one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_CLKIN = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned DIV = FREQ_CLKIN / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  logic          rxs_prev_q;
  logic          sample;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // rxs_prev_q, rxs and sync_q[0] hold the line one cycle before, at and one cycle after the
  // nominal sample point, so the vote resolves in the same cycle as a single sample would.
  assign sample = (rxs_prev_q & rxs) | (rxs_prev_q & sync_q[0]) | (rxs & sync_q[0]);
`else
  assign sample = rxs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is already high again at mid-bit is a glitch.
          state_d = sample ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitHigh: begin
        // Hold off until the line recovers so a long break reports only once.
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_hello_rx.sv
// Receive side of the "Hello World!\n" UART link: deserialises bytes and checks each
// newline-terminated line against HELLO_STR, counting exact matches.
// Optional build macro (in uart_rx): UART_RX_MAJORITY_EN.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx           UART line, idle high
//   rx_debug     copy of rx for a logic analyser
//   rx_data      last received byte
//   rx_valid     one-cycle strobe, rx_data is new
//   frame_err    one-cycle strobe, stop bit sampled low
//   line_ok      one-cycle strobe, line matched exactly
//   line_bad     one-cycle strobe, line ended without matching
//   match_count  number of line_ok events, saturating at 0xFFFF
module uart_hello_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_CLKIN = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        rx_debug,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        line_ok,
  output logic        line_bad,
  output logic [15:0] match_count
);

  logic [3:0]  idx_q, idx_d;
  logic        mism_q, mism_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;
  logic [15:0] count_q, count_d;

  assign rx_debug = rx;

  uart_rx #(
    .FREQ_CLKIN (FREQ_CLKIN),
    .BAUD_RATE  (BAUD_RATE)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      mism_q  <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    mism_d  = mism_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    count_d = count_q;
    if (frame_err) begin
      // A lost byte poisons the rest of the line.
      mism_d = 1'b1;
    end else if (rx_valid) begin
      if (rx_data == ASCII_LF) begin
        if (!mism_q && idx_q == 4'(HELLO_LEN - 1)) begin
          ok_d = 1'b1;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end else begin
          bad_d = 1'b1;
        end
        idx_d  = '0;
        mism_d = 1'b0;
      end else if (idx_q < 4'(HELLO_LEN - 1) && rx_data == hello_char(idx_q)) begin
        idx_d = idx_q + 4'd1;
      end else begin
        // Wrong character or line too long; idx holds so it cannot run past the string.
        mism_d = 1'b1;
      end
    end
  end

  assign line_ok     = ok_q;
  assign line_bad    = bad_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_uart_hello_rx.sv
// Self-checking bench for uart_hello_rx: table-driven single frames, hand-written corner
// sequences and randomised lines checked against a line-level reference model.
module tb_uart_hello_rx;

  localparam int unsigned FREQ = 1_600_000;
  localparam int unsigned BAUD = 100_000;
  localparam int DIV = 16;
  // Pin changes just after an edge, so T = pin cycle + 2; strobe at T + DIV/2 + 9*DIV + 1.
  localparam int LATENCY = 2 + DIV / 2 + 9 * DIV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rx_debug;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        line_ok;
  logic        line_bad;
  logic [15:0] match_count;

  uart_hello_rx #(
    .FREQ_CLKIN (FREQ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_debug    (rx_debug),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .line_ok     (line_ok),
    .line_bad    (line_bad),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         stop_low;  // 0: good stop bit, else cycles the stop bit is held low
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[7];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_ok = 0, n_lbad = 0;
  int last_valid_cyc = 0, last_ok_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur_line[$];
  bit cur_fe = 0;
  int exp_ok = 0, exp_bad = 0, exp_ferr = 0, exp_count = 0;
  string hello = "Hello World!\n";

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rx_valid) begin
        got_q.push_back(rx_data);
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (line_ok) begin
        n_ok++;
        last_ok_cyc = cyc;
      end
      if (line_bad) n_lbad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a line is good iff no byte was lost and its text equals the greeting.
  function automatic void model_byte(input logic [7:0] b);
    bit ok;
    exp_q.push_back(b);
    if (b == 8'h0A) begin
      ok = !cur_fe && cur_line.size() == hello.len() - 1;
      if (ok) begin
        for (int i = 0; i < hello.len() - 1; i++) begin
          if (cur_line[i] != hello[i]) ok = 0;
        end
      end
      if (ok) begin
        exp_ok++;
        if (exp_count < 65535) exp_count++;
      end else begin
        exp_bad++;
      end
      cur_line.delete();
      cur_fe = 0;
    end else begin
      cur_line.push_back(b);
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      tick(stop_low);
      rx = 1'b1;
      tick(DIV);
      cur_fe = 1;
      exp_ferr++;
    end else begin
      rx = 1'b1;
      tick(DIV);
      model_byte(b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 0);
  endtask

  task automatic check_bytes(input string name);
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, " byte"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_lines(input string name);
    check({name, " line_ok"}, n_ok, exp_ok);
    check({name, " line_bad"}, n_lbad, exp_bad);
    check({name, " frame_err"}, n_ferr, exp_ferr);
    check({name, " match_count"}, match_count, exp_count);
  endtask

  task automatic abort_with_reset(input logic [7:0] b);
    // Start a frame, reset in the middle of data bit 4.
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = b[4];
    tick(DIV / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset match_count", match_count, 16'h0000);
    check("reset strobes", {rx_valid, frame_err, line_ok, line_bad}, 4'b0000);
    tick(3);
    rst = 1'b0;
    cur_line.delete();
    cur_fe = 0;
    exp_count = 0;
    got_q.delete();
    exp_q.delete();
    tick(40);
  endtask

  initial begin
    int p, v0, f0, kind, len, pos;
    logic [7:0] line[$];
    logic [7:0] c;

    tbl[0] = '{8'h55, 0, 8'h55, 1, 0};
    tbl[1] = '{8'h00, 0, 8'h00, 1, 0};
    tbl[2] = '{8'hFF, 0, 8'hFF, 1, 0};
    tbl[3] = '{8'hA3, 0, 8'hA3, 1, 0};
    tbl[4] = '{8'h80, 0, 8'h80, 1, 0};
    tbl[5] = '{8'h01, 0, 8'h01, 1, 0};
    tbl[6] = '{8'h3C, 40, 8'h01, 0, 1};

    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset strobes", {rx_valid, frame_err, line_ok, line_bad}, 4'b0000);
    check("reset match_count", match_count, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);

    // Single frames from the table.
    for (int i = 0; i < 7; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      p  = cyc;
      send_frame(tbl[i].data, tbl[i].stop_low);
      tick(4);
      check("table rx_data", rx_data, tbl[i].exp_data);
      check("table rx_valid", n_valid - v0, tbl[i].exp_valid);
      check("table frame_err", n_ferr - f0, tbl[i].exp_ferr);
      if (tbl[i].exp_valid != 0) check("table latency", last_valid_cyc - p, LATENCY);
    end
    check_bytes("table");
    send_str("\n");
    tick(4);
    check_lines("table flush");

    // Exact line, back to back.
    send_str("Hello World!\n");
    tick(4);
    check_bytes("exact");
    check_lines("exact");
    check("exact ok after lf valid", last_ok_cyc - last_valid_cyc, 1);

    // Mismatched lines.
    send_str("Hello world!\n");
    send_str("Hello World!!\n");
    send_str("\n");
    tick(4);
    check_bytes("mismatch");
    check_lines("mismatch");

    // Framing error aborts its line; the next line is clean.
    send_frame(8'h41, 40);
    send_str("\n");
    send_str("Hello World!\n");
    tick(4);
    check_bytes("framing");
    check_lines("framing");

    // Short glitch on an idle line.
    v0 = n_valid;
    f0 = n_ferr + n_ok + n_lbad;
    rx = 1'b0;
    #1;
    check("rx_debug low", rx_debug, 1'b0);
    tick(3);
    rx = 1'b1;
    #1;
    check("rx_debug high", rx_debug, 1'b1);
    tick(200);
    check("glitch rx_valid", n_valid - v0, 0);
    check("glitch other strobes", n_ferr + n_ok + n_lbad - f0, 0);

    // Reset mid-frame, then a clean 0xA3 frame.
    send_str("Hello");
    abort_with_reset(8'h5A);
    v0 = n_valid;
    send_frame(8'hA3, 0);
    tick(4);
    check("post-reset rx_data", rx_data, 8'hA3);
    check("post-reset rx_valid", n_valid - v0, 1);
    send_str("\n");
    // Reset also drops a partial line.
    send_str("Hello W");
    abort_with_reset(8'hC6);
    send_str("Hello World!\n");
    tick(4);
    check_bytes("reset");
    check_lines("reset");

    // Randomised lines.
    for (int l = 0; l < 10; l++) begin
      line.delete();
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        len = $urandom_range(0, 14);
        for (int i = 0; i < len; i++) line.push_back(8'($urandom_range(32, 126)));
      end else begin
        for (int i = 0; i < hello.len() - 1; i++) line.push_back(hello[i]);
        if (kind == 1) begin
          pos = $urandom_range(0, 11);
          c = 8'($urandom_range(32, 126));
          if (c == line[pos]) c = c + 8'd1;
          line[pos] = c;
        end else if (kind == 3) begin
          line.push_back(8'($urandom_range(32, 126)));
        end
      end
      line.push_back(8'h0A);
      foreach (line[i]) begin
        send_frame(line[i], 0);
        tick($urandom_range(0, 5));
      end
    end
    tick(4);
    check_bytes("random");
    check_lines("random");

    // Saturation of the match counter.
    force dut.count_q = 16'hFFFE;
    tick(1);
    release dut.count_q;
    exp_count = 16'hFFFE;
    send_str("Hello World!\n");
    tick(4);
    check_lines("saturate to max");
    send_str("Hello World!\n");
    tick(4);
    check_lines("saturate hold");
    check_bytes("saturate");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
